prbs_checker: RTL and testbench

- Consumes the word-per-cycle output stream of the team's Fibonacci LFSR (shift right, feedback into the MSB).
- Self-synchronises a local copy of the LFSR, declares lock, then counts mismatches against the local model.
- Sits directly downstream of the LFSR in the pattern-generator/BIST path; its error count is the pass/fail signature of the link under test.

---
 rtl/prbs_pkg.sv | 28 ++
 rtl/prbs_checker_satcnt.sv | 27 ++
 rtl/prbs_checker.sv | 126 ++++++++++++
 tb/tb_prbs_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker and its companion LFSR generator.
package prbs_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    HUNT_SEED,
    HUNT,
    LOCKED
  } state_t;

  // Fibonacci step: shift right, XOR of the tapped bits enters at the MSB.
  function automatic logic [MAXW-1:0] lfsr_next(input logic [MAXW-1:0] word,
                                                input logic [MAXW-1:0] taps,
                                                input int width);
    logic fb;
    fb = ^(word & taps);
    return (word >> 1) | (MAXW'(fb) << (width - 1));
  endfunction

  function automatic int unsigned popcount(input logic [MAXW-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAXW; i++) c = c + 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/prbs_checker_satcnt.sv
// Saturating up-counter with synchronous clear and a variable increment.
module satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] inc,
  output logic [W-1:0] count
);

  logic [W-1:0] base;
  logic [W:0]   sum;

  // Clear replaces the old value, so a simultaneous increment still lands.
  always_comb begin
    base = clear ? '0 : count;
    sum  = {1'b0, base} + {1'b0, inc};
  end

  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (sum[W]) count <= '1;
    else             count <= sum[W-1:0];
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for the Fibonacci LFSR word stream.
// Define PRBS_CHK_BITERR_EN to count bit errors instead of word errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = 7,
  parameter logic [WIDTH-1:0] TAPS     = 7'h60,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_CNT = 4,
  parameter int               ERRW     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int MW = $clog2(LOCK_CNT) + 1;
  localparam int LW = $clog2(LOSS_CNT) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             word_match, nonzero;
  logic             err_hit;
  logic [ERRW-1:0]  inc;
  logic [WIDTH-1:0] next_in, next_exp;

  assign word_match = (data_in == exp_q);
  assign nonzero    = (data_in != '0);
  assign next_in    = WIDTH'(lfsr_next(MAXW'(data_in), MAXW'(TAPS), WIDTH));
  assign next_exp   = WIDTH'(lfsr_next(MAXW'(exp_q), MAXW'(TAPS), WIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT_SEED;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_hit;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (valid) begin
      case (state_q)
        HUNT_SEED: begin
          if (nonzero) begin
            exp_d   = next_in;
            match_d = '0;
            state_d = HUNT;
          end
        end
        HUNT: begin
          if (word_match && nonzero) begin
            exp_d = next_in;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else if (nonzero) begin
            exp_d   = next_in;
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = HUNT_SEED;
          end
        end
        LOCKED: begin
          exp_d = next_exp;
          if (word_match) begin
            miss_d = '0;
          end else if (miss_q == LW'(LOSS_CNT - 1)) begin
            miss_d  = '0;
            match_d = '0;
            state_d = HUNT_SEED;
          end else begin
            miss_d = miss_q + LW'(1);
          end
        end
        default: state_d = HUNT_SEED;
      endcase
    end
  end

  always_comb begin
    err_hit = valid && (state_q == LOCKED) && !word_match;
    inc     = '0;
    if (err_hit) begin
`ifdef PRBS_CHK_BITERR_EN
      inc = ERRW'(popcount(MAXW'(data_in ^ exp_q)));
`else
      inc = ERRW'(1);
`endif
    end
  end

  satcnt #(.W(ERRW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .inc   (inc),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker, scored against a word-level sequence model.
module tb_prbs_checker;

  localparam int ERRW = 4;
  localparam int CMAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid = 1'b0;
  logic [6:0]      data_in = '0;
  logic            clear_cnt = 1'b0;
  logic            locked;
  logic            err_pulse;
  logic [ERRW-1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  int         m_mode = 0;
  logic [6:0] m_prev = '0;
  logic [6:0] m_ref = '0;
  int         m_run = 0;
  int         m_miss = 0;
  int         m_locked = 0;
  int         m_pulse = 0;
  int         m_cnt = 0;

  logic [6:0] gen;

  prbs_checker #(
    .WIDTH    (7),
    .TAPS     (7'h60),
    .LOCK_CNT (8),
    .LOSS_CNT (4),
    .ERRW     (ERRW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .data_in   (data_in),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] nxt(input logic [6:0] w);
    return {w[6] ^ w[5], w[6:1]};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: track the position in the m-sequence rather than hardware state.
  task automatic modelStep(input bit rst, input bit v, input logic [6:0] d, input bit clr);
    int inc;
    inc = 0;
    m_pulse = 0;
    if (rst) begin
      m_mode = 0; m_run = 0; m_miss = 0;
      m_locked = 0; m_cnt = 0;
      return;
    end
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_prev = d; m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == 0) begin
          m_mode = 0; m_run = 0;
        end else if (d == nxt(m_prev)) begin
          m_prev = d; m_run++;
          if (m_run == 8) begin m_mode = 2; m_ref = nxt(d); m_miss = 0; end
        end else begin
          m_prev = d; m_run = 0;
        end
      end else begin
        if (d == m_ref) m_miss = 0;
        else begin
          m_pulse = 1;
`ifdef PRBS_CHK_BITERR_EN
          inc = $countones(d ^ m_ref);
`else
          inc = 1;
`endif
          m_miss++;
          if (m_miss == 4) begin m_mode = 0; m_run = 0; end
        end
        m_ref = nxt(m_ref);
      end
    end
    m_cnt = (clr ? 0 : m_cnt) + inc;
    if (m_cnt > CMAX) m_cnt = CMAX;
    m_locked = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [6:0] d, input bit clr);
    reset = rst; valid = v; data_in = d; clear_cnt = clr;
    @(posedge clk);
    modelStep(rst, v, d, clr);
    #1;
  endtask

  task automatic sendWord(input logic [6:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic sendGood();
    sendWord(gen);
    gen = nxt(gen);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 7'($urandom), 1'b0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("locked", int'(locked), m_locked);
      checkOutput("err_pulse", int'(err_pulse), m_pulse);
      checkOutput("err_cnt", int'(err_cnt), m_cnt);
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 7'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 7'h00, 1'b0);
    cmp_en = 1'b1;
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_cnt", int'(err_cnt), 0);

    gen = 7'h7F;
    for (int i = 1; i <= 9; i++) begin
      sendGood();
      if (i == 8) checkOutput("lock_early", int'(locked), 0);
      if (i == 9) checkOutput("lock_on_9th", int'(locked), 1);
    end
    checkOutput("lock_cnt_zero", int'(err_cnt), 0);

    sendWord(gen ^ 7'h01);
    gen = nxt(gen);
    checkOutput("single_err_pulse", int'(err_pulse), 1);
    checkOutput("single_err_cnt", int'(err_cnt), 1);
    checkOutput("single_err_locked", int'(locked), 1);
    sendGood();
    checkOutput("pulse_one_cycle", int'(err_pulse), 0);

    idle(10);
    checkOutput("idle_locked", int'(locked), 1);
    checkOutput("idle_cnt", int'(err_cnt), 1);
    for (int i = 0; i < 3; i++) sendGood();

    for (int i = 1; i <= 4; i++) begin
      sendWord(7'h00);
      gen = nxt(gen);
      if (i == 3) checkOutput("loss_still_locked", int'(locked), 1);
    end
    checkOutput("loss_unlocked", int'(locked), 0);
    checkOutput("loss_last_pulse", int'(err_pulse), 1);
`ifndef PRBS_CHK_BITERR_EN
    checkOutput("loss_cnt", int'(err_cnt), 5);
`endif
    applyStimulus(1'b0, 1'b0, 7'h00, 1'b1);
    checkOutput("clear_cnt", int'(err_cnt), 0);

    for (int i = 1; i <= 9; i++) begin
      sendGood();
      if (i == 4) idle(10);
      if (i == 8) checkOutput("relock_early", int'(locked), 0);
    end
    checkOutput("relock_on_9th", int'(locked), 1);

    for (int i = 0; i < 20; i++) begin
      sendWord(gen ^ 7'(1 << (i % 7)));
      gen = nxt(gen);
      sendGood();
    end
    checkOutput("sat_cnt", int'(err_cnt), 15);
    checkOutput("sat_locked", int'(locked), 1);
    sendWord(gen ^ 7'h01);
    gen = nxt(gen);
    applyStimulus(1'b0, 1'b1, gen ^ 7'h02, 1'b1);
    gen = nxt(gen);
    checkOutput("clear_with_err", int'(err_cnt), 1);

    for (int i = 0; i < 3; i++) sendGood();
    applyStimulus(1'b1, 1'b1, gen, 1'b0);
    applyStimulus(1'b1, 1'b1, nxt(gen), 1'b0);
    checkOutput("midreset_locked", int'(locked), 0);
    checkOutput("midreset_pulse", int'(err_pulse), 0);
    checkOutput("midreset_cnt", int'(err_cnt), 0);

    gen = 7'h7F;
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit v, clr, rst;
      logic [6:0] d;
      r   = int'($urandom_range(0, 99));
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (r < 80)      d = gen;
      else if (r < 88) d = gen ^ 7'(1 << $urandom_range(0, 6));
      else if (r < 93) d = 7'h00;
      else             d = 7'($urandom);
      if ($urandom_range(0, 399) == 0) gen = 7'($urandom_range(1, 127));
      applyStimulus(rst, v, d, clr);
      if (v) gen = nxt(gen);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
